// File: rtl/fp_pkg.sv
// Shared constants and types for the binary32 output-side datapath.
// Holds field widths, canonical encodings, flag bit positions and FSM states.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int SIG_W    = 28;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Bit positions within the {overflow, underflow, inexact} flag vector.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even incrementer on a 28-bit significand
// whose three low bits are guard, round and sticky.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             carry_o,
    output logic             inexact_o
);

    logic        round_up;
    logic [24:0] sum;

    always_comb begin
        round_up  = sig_i[2] & (sig_i[1] | sig_i[0] | sig_i[3]);
        inexact_o = |sig_i[2:0];
        sum       = sig_i[27:3] + 25'(round_up);
        // GRS bits are consumed by rounding, so they come back cleared.
        sig_o     = {sum, 3'b000};
        carry_o   = sum[24];
    end

endmodule

// File: rtl/fp_norm_round_pack.sv
// Iterative normalize / round / pack stage producing an IEEE-754 binary32 word
// from an unpacked sign, signed exponent and widened significand.
module fp_norm_round_pack
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_sig,
    input  logic        in_nan,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [10:0] exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [31:0]        result_q, result_d;
    logic [2:0]         flags_q, flags_d;

    logic [SIG_W-1:0]   rnd_sig;
    logic               rnd_carry;
    logic               rnd_nx;
    logic [SIG_W-1:0]   sig_r;
    logic signed [10:0] exp_r;
    logic               tiny;

    fp_round_rne u_round (
        .sig_i     (sig_q),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_nx)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        result_d = result_q;
        flags_d  = flags_q;
        tiny     = ~sig_q[26];
        sig_r    = rnd_carry ? (rnd_sig >> 1) : rnd_sig;
        exp_r    = exp_q + 11'(rnd_carry);

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {in_exp[9], in_exp};
                    sig_d   = in_sig;
                    flags_d = 3'b000;
                    if (in_nan) begin
                        result_d = QNAN;
                        state_d  = ST_DONE;
                    end else if (in_inf) begin
                        result_d = {in_sign, 8'hFF, 23'b0};
                        state_d  = ST_DONE;
                    end else if (in_sig == '0) begin
                        result_d = {in_sign, 31'b0};
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (sig_q[27]) begin
                    sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + 11'sd1;
                end else if (exp_q < -11'sd26) begin
                    // Far below the subnormal range: only the sticky survives.
                    sig_d = {27'b0, |sig_q};
                    exp_d = 11'sd1;
                end else if (exp_q < 11'sd1) begin
                    sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + 11'sd1;
                end else if (!sig_q[26] && (exp_q > 11'sd1)) begin
                    sig_d = sig_q << 1;
                    exp_d = exp_q - 11'sd1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                sig_d = sig_r;
                exp_d = exp_r;
                if (exp_r >= 11'(EXP_MAX)) begin
                    result_d         = {sign_q, 8'hFF, 23'b0};
                    flags_d          = '0;
                    flags_d[FLAG_OF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else begin
                    // A subnormal that rounds into bit 26 keeps exp==1, i.e. becomes the smallest normal.
                    result_d         = {sign_q, (sig_r[26] ? exp_r[7:0] : 8'h00), sig_r[25:3]};
                    flags_d          = '0;
                    flags_d[FLAG_UF] = tiny & rnd_nx;
                    flags_d[FLAG_NX] = rnd_nx;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed bench for fp_norm_round_pack: hand-computed results, flags and latencies.
module tb_fp_norm_round_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_sig;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int n_cmp;
    int n_err;

    fp_norm_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_nan     (in_nan),
        .in_inf     (in_inf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drives one transaction and returns when out_valid is seen (or the bound expires).
    task automatic launch(input logic s, input logic [9:0] e, input logic [27:0] g,
                          input logic nan, input logic inf, output int lat);
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_sig   = g;
        in_nan   = nan;
        in_inf   = inf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                          input logic [27:0] g, input logic nan, input logic inf,
                          input logic [31:0] want_res, input logic [2:0] want_flags,
                          input int want_lat);
        int lat;
        launch(s, e, g, nan, inf, lat);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
        chk({tag, "_res"}, out_result, want_res);
        chk({tag, "_flags"}, 32'(out_flags), 32'(want_flags));
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        // out_ready is high, so the handshake completes on the next edge.
        @(posedge clk);
        #1;
        chk({tag, "_release"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sig    = '0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {28'b0, in_ready, out_valid, 2'b0}, {28'b0, 1'b1, 1'b0, 2'b0});
        chk("rst_result", out_result, 32'h0);
        chk("rst_flags", 32'(out_flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one",       1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 3'b000, 3);
        run_op("lshift3",   1'b0, 10'd130, 28'h0800000, 1'b0, 1'b0, 32'h3F800000, 3'b000, 6);
        run_op("subn_min",  1'b0, 10'd1,   28'h0000008, 1'b0, 1'b0, 32'h00000001, 3'b000, 3);
        run_op("ovf_tie",   1'b0, 10'd254, 28'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, 3'b101, 3);
        run_op("clamp",     1'b1, 10'h3E2, 28'h4000000, 1'b0, 1'b0, 32'h80000000, 3'b011, 4);
        run_op("carry_in",  1'b0, 10'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, 3'b000, 4);
        run_op("rshift1",   1'b0, 10'd0,   28'h4000000, 1'b0, 1'b0, 32'h00400000, 3'b000, 4);
        run_op("tie_even",  1'b0, 10'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 3'b001, 3);
        run_op("above_half",1'b0, 10'd127, 28'h4000006, 1'b0, 1'b0, 32'h3F800001, 3'b001, 3);
        run_op("subn2norm", 1'b0, 10'd1,   28'h3FFFFFC, 1'b0, 1'b0, 32'h00800000, 3'b011, 3);
        run_op("neg_inf",   1'b1, 10'd5,   28'h4000000, 1'b0, 1'b1, 32'hFF800000, 3'b000, 1);
        run_op("neg_zero",  1'b1, 10'd5,   28'h0000000, 1'b0, 1'b0, 32'h80000000, 3'b000, 1);

        // NaN wins over infinity; result held while downstream stalls.
        out_ready = 1'b0;
        launch(1'b1, 10'd0, 28'h0, 1'b1, 1'b1, lat);
        chk("nan_lat", 32'(lat), 32'd1);
        chk("nan_res", out_result, 32'h7FC00000);
        chk("nan_flags", 32'(out_flags), 32'h0);
        held = out_result;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_res", out_result, held);
            chk("hold_state", {30'b0, out_valid, in_ready}, 32'b10);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", {30'b0, out_valid, in_ready}, 32'b01);

        // Reset in the middle of normalisation aborts with no output.
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 10'd130;
        in_sig   = 28'h0800000;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {30'b0, out_valid, in_ready}, 32'b01);
        chk("mid_rst_result", out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'b0, out_valid, in_ready}, 32'b01);
        run_op("after_rst", 1'b0, 10'd128, 28'h6000000, 1'b0, 1'b0, 32'h40400000, 3'b000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
